// File: rtl/axi_stream_merge_channel.sv
// Rejoins a "first" packet and a following "end" packet into one AXI-Stream packet.
// One registered output stage (1-cycle latency); first-segment length is checked against merge_len.
module axi_stream_merge_channel #(
  parameter int DSIZE = 8,
  parameter int KSIZE = (DSIZE / 8 > 0) ? DSIZE / 8 : 1,
  parameter int USIZE = 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [15:0]      merge_len,
  input  logic [DSIZE-1:0] first_axis_tdata,
  input  logic [KSIZE-1:0] first_axis_tkeep,
  input  logic [USIZE-1:0] first_axis_tuser,
  input  logic             first_axis_tlast,
  input  logic             first_axis_tvalid,
  output logic             first_axis_tready,
  input  logic [DSIZE-1:0] end_axis_tdata,
  input  logic [KSIZE-1:0] end_axis_tkeep,
  input  logic [USIZE-1:0] end_axis_tuser,
  input  logic             end_axis_tlast,
  input  logic             end_axis_tvalid,
  output logic             end_axis_tready,
  output logic [DSIZE-1:0] out_axis_tdata,
  output logic [KSIZE-1:0] out_axis_tkeep,
  output logic [USIZE-1:0] out_axis_tuser,
  output logic             out_axis_tlast,
  output logic             out_axis_tvalid,
  input  logic             out_axis_tready,
  output logic             len_err
);

  typedef enum logic {S_FIRST = 1'b0, S_END = 1'b1} state_t;

  state_t           state_q;
  logic [DSIZE-1:0] tdata_q;
  logic [KSIZE-1:0] tkeep_q;
  logic [USIZE-1:0] tuser_q;
  logic             tlast_q;
  logic             tvalid_q;
  logic             len_err_q;
  logic [15:0]      cnt_q;
  logic [15:0]      cnt_d;
  logic             load;
  logic             first_acc;
  logic             end_acc;
  logic             len_bad;

  assign load              = !tvalid_q || out_axis_tready;
  assign first_axis_tready = aresetn && (state_q == S_FIRST) && load;
  assign end_axis_tready   = aresetn && (state_q == S_END) && load;
  assign first_acc         = first_axis_tvalid && first_axis_tready;
  assign end_acc           = end_axis_tvalid && end_axis_tready;

  always_comb begin
    cnt_d = cnt_q;
    if (first_acc) begin
      if (first_axis_tlast) begin
        cnt_d = 16'd0;
      end else if (cnt_q != 16'hFFFF) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  // 17-bit compare so a saturated count can never alias to a small merge_len
  assign len_bad = (merge_len != 16'd0) &&
                   (({1'b0, cnt_q} + 17'd1) != {1'b0, merge_len});

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= S_FIRST;
      tdata_q   <= '0;
      tkeep_q   <= '0;
      tuser_q   <= '0;
      tlast_q   <= 1'b0;
      tvalid_q  <= 1'b0;
      len_err_q <= 1'b0;
      cnt_q     <= 16'd0;
    end else begin
      cnt_q     <= cnt_d;
      len_err_q <= first_acc && first_axis_tlast && len_bad;
      if (load) begin
        if (state_q == S_FIRST) begin
          tvalid_q <= first_acc;
          if (first_acc) begin
            tdata_q <= first_axis_tdata;
            tkeep_q <= first_axis_tkeep;
            tuser_q <= first_axis_tuser;
            tlast_q <= 1'b0;
          end
        end else begin
          tvalid_q <= end_acc;
          if (end_acc) begin
            tdata_q <= end_axis_tdata;
            tkeep_q <= end_axis_tkeep;
            tuser_q <= end_axis_tuser;
            tlast_q <= end_axis_tlast;
          end
        end
      end
      case (state_q)
        S_FIRST: if (first_acc && first_axis_tlast) state_q <= S_END;
        S_END:   if (end_acc && end_axis_tlast) state_q <= S_FIRST;
        default: state_q <= S_FIRST;
      endcase
    end
  end

  assign out_axis_tdata  = tdata_q;
  assign out_axis_tkeep  = tkeep_q;
  assign out_axis_tuser  = tuser_q;
  assign out_axis_tlast  = tlast_q;
  assign out_axis_tvalid = tvalid_q;
  assign len_err         = len_err_q;

endmodule

// File: tb/tb_axi_stream_merge_channel.sv
// Scoreboard bench for axi_stream_merge_channel: packet-level model, randomized valid/ready.
module tb_axi_stream_merge_channel;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  k;
    logic [2:0]  u;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [15:0] merge_len = 16'd0;
  logic [15:0] first_axis_tdata = '0;
  logic [1:0]  first_axis_tkeep = '0;
  logic [2:0]  first_axis_tuser = '0;
  logic        first_axis_tlast = 1'b0;
  logic        first_axis_tvalid = 1'b0;
  logic        first_axis_tready;
  logic [15:0] end_axis_tdata = '0;
  logic [1:0]  end_axis_tkeep = '0;
  logic [2:0]  end_axis_tuser = '0;
  logic        end_axis_tlast = 1'b0;
  logic        end_axis_tvalid = 1'b0;
  logic        end_axis_tready;
  logic [15:0] out_axis_tdata;
  logic [1:0]  out_axis_tkeep;
  logic [2:0]  out_axis_tuser;
  logic        out_axis_tlast;
  logic        out_axis_tvalid;
  logic        out_axis_tready = 1'b0;
  logic        len_err;

  axi_stream_merge_channel #(.DSIZE(16), .KSIZE(2), .USIZE(3)) dut (
    .aclk(clk), .aresetn(aresetn), .merge_len(merge_len),
    .first_axis_tdata(first_axis_tdata), .first_axis_tkeep(first_axis_tkeep),
    .first_axis_tuser(first_axis_tuser), .first_axis_tlast(first_axis_tlast),
    .first_axis_tvalid(first_axis_tvalid), .first_axis_tready(first_axis_tready),
    .end_axis_tdata(end_axis_tdata), .end_axis_tkeep(end_axis_tkeep),
    .end_axis_tuser(end_axis_tuser), .end_axis_tlast(end_axis_tlast),
    .end_axis_tvalid(end_axis_tvalid), .end_axis_tready(end_axis_tready),
    .out_axis_tdata(out_axis_tdata), .out_axis_tkeep(out_axis_tkeep),
    .out_axis_tuser(out_axis_tuser), .out_axis_tlast(out_axis_tlast),
    .out_axis_tvalid(out_axis_tvalid), .out_axis_tready(out_axis_tready),
    .len_err(len_err)
  );

  initial forever #5 clk = ~clk;

  beat_t fq[$];
  beat_t eq[$];
  beat_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    err_exp = 0;
  int    lerr_cnt = 0;
  int    lerr_cyc = -1;
  int    f_cnt = 0;
  int    f0_cyc = -1, flast_cyc = -1, e0_cyc = -1;
  int    out0_cyc = -1, olast_cyc = -1;
  bit    rnd_vld = 1'b0, rnd_rdy = 1'b0;
  bit    f_fire = 1'b0, e_fire = 1'b0, f_sop = 1'b1, e_sop = 1'b1;
  bit    out_start = 1'b1, prev_stall = 1'b0, prev_lerr = 1'b0;
  beat_t prev_beat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic gen_pkt(input int flen, input int elen);
    beat_t b;
    for (int i = 0; i < flen; i++) begin
      b.d = 16'($urandom); b.k = 2'($urandom); b.u = 3'($urandom);
      b.l = (i == flen - 1);
      fq.push_back(b);
      b.l = 1'b0;
      exp_q.push_back(b);
    end
    for (int i = 0; i < elen; i++) begin
      b.d = 16'($urandom); b.k = 2'($urandom); b.u = 3'($urandom);
      b.l = (i == elen - 1);
      eq.push_back(b);
      exp_q.push_back(b);
    end
    if (merge_len != 16'd0 && flen != int'(merge_len)) err_exp++;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((fq.size() != 0 || eq.size() != 0 || exp_q.size() != 0) && n < 60000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #2;
    chk({nm, "_drained"}, 64'(exp_q.size()), 64'd0);
    chk({nm, "_len_err_count"}, 64'(lerr_cnt), 64'(err_exp));
  endtask

  // Driver: all stream inputs change at negedge; handshakes are sampled 1 time unit later.
  always begin
    @(negedge clk);
    if (!aresetn) begin
      fq.delete();
      eq.delete();
      first_axis_tvalid = 1'b0;
      end_axis_tvalid = 1'b0;
      f_sop = 1'b1;
      e_sop = 1'b1;
    end else begin
      if (f_fire) fq.delete(0);
      if (e_fire) eq.delete(0);
      if (!first_axis_tvalid || f_fire) begin
        if (fq.size() > 0 && (!rnd_vld || $urandom_range(0, 1) == 1)) begin
          {first_axis_tdata, first_axis_tkeep, first_axis_tuser, first_axis_tlast} = fq[0];
          first_axis_tvalid = 1'b1;
        end else first_axis_tvalid = 1'b0;
      end
      if (!end_axis_tvalid || e_fire) begin
        if (eq.size() > 0 && (!rnd_vld || $urandom_range(0, 1) == 1)) begin
          {end_axis_tdata, end_axis_tkeep, end_axis_tuser, end_axis_tlast} = eq[0];
          end_axis_tvalid = 1'b1;
        end else end_axis_tvalid = 1'b0;
      end
    end
    out_axis_tready = !rnd_rdy || ($urandom_range(0, 1) == 1);
    #1;
    f_fire = first_axis_tvalid && first_axis_tready;
    e_fire = end_axis_tvalid && end_axis_tready;
    if (f_fire) begin
      f_cnt++;
      if (f_sop) f0_cyc = cyc;
      f_sop = first_axis_tlast;
      if (first_axis_tlast) flast_cyc = cyc;
    end
    if (e_fire) begin
      if (e_sop) e0_cyc = cyc;
      e_sop = end_axis_tlast;
    end
  end

  // Monitor: pops the scoreboard on every output handshake
  always begin
    beat_t got;
    beat_t want;
    @(negedge clk);
    #1;
    got = {out_axis_tdata, out_axis_tkeep, out_axis_tuser, out_axis_tlast};
    if (!aresetn) begin
      out_start = 1'b1;
      prev_stall = 1'b0;
      prev_lerr = 1'b0;
    end else begin
      if (len_err) begin
        chk("len_err_single_cycle", 64'(prev_lerr), 64'd0);
        lerr_cnt++;
        lerr_cyc = cyc;
      end
      prev_lerr = len_err;
      if (prev_stall) chk("out_hold_stable", {out_axis_tvalid, got}, {1'b1, prev_beat});
      if (out_start && out_axis_tvalid) begin
        out0_cyc = cyc;
        out_start = 1'b0;
      end
      if (out_axis_tvalid && out_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk("out_unexpected_beat", 64'(got), 64'd0);
          if (got == 0) begin
            failures++;
            $display("FAIL out_unexpected_beat: got zero beat with empty scoreboard");
          end
        end else begin
          want = exp_q.pop_front();
          chk("out_beat", 64'(got), 64'(want));
        end
        if (out_axis_tlast) begin
          out_start = 1'b1;
          olast_cyc = cyc;
        end
      end
      prev_stall = out_axis_tvalid && !out_axis_tready;
      prev_beat = got;
    end
  end

  initial begin
    int pre;
    beat_t b;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_tvalid", 64'(out_axis_tvalid), 64'd0);
    chk("rst_out_fields", {out_axis_tdata, out_axis_tkeep, out_axis_tuser, out_axis_tlast}, 64'd0);
    chk("rst_len_err", 64'(len_err), 64'd0);
    chk("rst_treadys", {first_axis_tready, end_axis_tready}, 64'd0);
    aresetn = 1'b1;

    // 1: 4+3 merge, matching length, continuous flow
    merge_len = 16'd4;
    gen_pkt(4, 3);
    drain("t1");
    chk("t1_first_out_latency", 64'(out0_cyc - f0_cyc), 64'd1);
    chk("t1_no_bubbles", 64'(olast_cyc - out0_cyc), 64'd6);

    // 2: length mismatch still merges
    @(posedge clk); #2;
    merge_len = 16'd5;
    gen_pkt(4, 3);
    drain("t2");
    chk("t2_len_err_timing", 64'(lerr_cyc - flast_cyc), 64'd1);

    // 3: end valid from the start, 3-beat first
    @(posedge clk); #2;
    merge_len = 16'd3;
    gen_pkt(3, 4);
    drain("t3");
    chk("t3_end_accept_after_first_last", 64'(e0_cyc - flast_cyc), 64'd1);
    chk("t3_no_bubbles", 64'(olast_cyc - out0_cyc), 64'd6);

    // 6: single+single beat with chosen keep/user, check disabled
    @(posedge clk); #2;
    merge_len = 16'd0;
    b = '{d: 16'hA5A5, k: 2'b01, u: 3'b101, l: 1'b1};
    fq.push_back(b); b.l = 1'b0; exp_q.push_back(b);
    b = '{d: 16'h5A5A, k: 2'b10, u: 3'b010, l: 1'b1};
    eq.push_back(b); exp_q.push_back(b);
    drain("t6");
    chk("t6_two_beats", 64'(olast_cyc - out0_cyc), 64'd1);

    // 1b: merge_len=1 with single-beat first packet is not an error
    @(posedge clk); #2;
    merge_len = 16'd1;
    gen_pkt(1, 2);
    drain("t_len1");

    // 4: random traffic, half unchecked lengths, half checked
    rnd_vld = 1'b1;
    rnd_rdy = 1'b1;
    @(posedge clk); #2;
    merge_len = 16'd0;
    for (int i = 0; i < 50; i++) gen_pkt($urandom_range(1, 16), $urandom_range(1, 64));
    drain("t4a");
    @(posedge clk); #2;
    merge_len = 16'd5;
    for (int i = 0; i < 50; i++) gen_pkt($urandom_range(1, 16), $urandom_range(1, 64));
    drain("t4b");
    rnd_vld = 1'b0;
    rnd_rdy = 1'b0;

    // 5: reset after A1 accepted, then a fresh 2+2 packet
    @(posedge clk); #2;
    merge_len = 16'd2;
    pre = f_cnt;
    gen_pkt(4, 2);
    for (int n = 0; n < 100 && f_cnt < pre + 2; n++) begin
      @(posedge clk); #2;
    end
    chk("t5_two_first_beats_taken", 64'(f_cnt - pre), 64'd2);
    aresetn = 1'b0;
    #1;
    chk("t5_treadys_in_reset", {first_axis_tready, end_axis_tready}, 64'd0);
    @(posedge clk); #2;
    aresetn = 1'b1;
    exp_q.delete();
    err_exp = lerr_cnt;
    #1;
    chk("t5_out_tvalid_cleared", 64'(out_axis_tvalid), 64'd0);
    chk("t5_out_fields_cleared", {out_axis_tdata, out_axis_tkeep, out_axis_tuser, out_axis_tlast}, 64'd0);
    chk("t5_back_in_first", {first_axis_tready, end_axis_tready}, 64'b10);
    gen_pkt(2, 2);
    drain("t5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
